// File: rtl/iob_merge.sv
// iob_merge: N-manager to 1-subordinate IOb-native arbiter with read-owner tracking.
// Optional build macro IOB_MERGE_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module iob_merge #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int N      = 2
) (
  input  logic                  clk_i,
  input  logic                  cke_i,
  input  logic                  rst_n_i,
  input  logic [N-1:0]          avalid_i,
  input  logic [N*ADDR_W-1:0]   addr_i,
  input  logic [N*DATA_W-1:0]   wdata_i,
  input  logic [N*DATA_W/8-1:0] wstrb_i,
  output logic [N-1:0]          ready_o,
  output logic [N*DATA_W-1:0]   rdata_o,
  output logic [N-1:0]          rvalid_o,
  output logic                  avalid_o,
  output logic [ADDR_W-1:0]     addr_o,
  output logic [DATA_W-1:0]     wdata_o,
  output logic [DATA_W/8-1:0]   wstrb_o,
  input  logic                  ready_i,
  input  logic [DATA_W-1:0]     rdata_i,
  input  logic                  rvalid_i
);
  localparam int NBITS = $clog2(N) + ($clog2(N) == 0);
  localparam int SW    = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, HOLD, RDWAIT} state_t;

  state_t           r_state, w_state_nxt;
  logic [NBITS-1:0] r_owner, w_owner_nxt;
  logic [NBITS-1:0] w_ptr, w_grant, w_sel, w_idx;
  logic             w_any, w_fwd, w_acc, w_rd;
  logic [SW-1:0]    w_wstrb_sel;

  function automatic logic [NBITS-1:0] inc_mod(input logic [NBITS-1:0] v);
    if (int'(v) >= N - 1) return '0;
    return v + 1'b1;
  endfunction

  // Rotating search: first requester at or after the pointer, wrapping to 0.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int i = 0; i < N; i++) begin
      w_idx = NBITS'((int'(w_ptr) + i) % N);
      if (!w_any && avalid_i[w_idx]) begin
        w_any   = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  assign w_sel       = (r_state == HOLD) ? r_owner : w_grant;
  assign w_fwd       = rst_n_i && (((r_state == IDLE) && w_any) ||
                                   ((r_state == HOLD) && avalid_i[r_owner]));
  assign w_acc       = w_fwd && ready_i;
  assign w_wstrb_sel = wstrb_i[int'(w_sel)*SW +: SW];
  assign w_rd        = ~|w_wstrb_sel;

  always_comb begin
    avalid_o = w_fwd;
    addr_o   = '0;
    wdata_o  = '0;
    wstrb_o  = '0;
    ready_o  = '0;
    if (w_fwd) begin
      addr_o         = addr_i[int'(w_sel)*ADDR_W +: ADDR_W];
      wdata_o        = wdata_i[int'(w_sel)*DATA_W +: DATA_W];
      wstrb_o        = w_wstrb_sel;
      ready_o[w_sel] = ready_i;
    end
  end

  always_comb begin
    rvalid_o = '0;
    if (rst_n_i && (r_state == RDWAIT) && rvalid_i) rvalid_o[r_owner] = 1'b1;
  end

  assign rdata_o = {N{rdata_i}};

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    case (r_state)
      IDLE: if (w_any) begin
        w_owner_nxt = w_grant;
        if (!ready_i)  w_state_nxt = HOLD;
        else if (w_rd) w_state_nxt = RDWAIT;
      end
      // A manager that drops avalid while locked simply releases the lock.
      HOLD: if (!avalid_i[r_owner]) w_state_nxt = IDLE;
            else if (ready_i)       w_state_nxt = w_rd ? RDWAIT : IDLE;
      RDWAIT: if (rvalid_i) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
      r_owner <= '0;
    end else if (cke_i) begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
    end
  end

`ifdef IOB_MERGE_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [NBITS-1:0] r_ptr;
  always_ff @(posedge clk_i) begin
    if (!rst_n_i)            r_ptr <= '0;
    else if (cke_i && w_acc) r_ptr <= inc_mod(w_sel);
  end
  assign w_ptr = r_ptr;
`endif

endmodule

// File: tb/tb_iob_merge.sv
// Self-checking bench for iob_merge (N=2): directed scenarios plus a randomized run vs. a transaction-level model.
module tb_iob_merge;
  localparam int N = 2;
`ifdef IOB_MERGE_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0, cke, rst_n;
  logic [1:0]  avalid;
  logic [63:0] addr, wdata;
  logic [7:0]  wstrb;
  logic        ready, rvalid;
  logic [31:0] rdata;
  logic [1:0]  ready_o, rvalid_o;
  logic [63:0] rdata_o;
  logic        avalid_o;
  logic [31:0] addr_o, wdata_o;
  logic [3:0]  wstrb_o;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  iob_merge #(.DATA_W(32), .ADDR_W(32), .N(N)) dut (
    .clk_i(clk), .cke_i(cke), .rst_n_i(rst_n),
    .avalid_i(avalid), .addr_i(addr), .wdata_i(wdata), .wstrb_i(wstrb),
    .ready_o(ready_o), .rdata_o(rdata_o), .rvalid_o(rvalid_o),
    .avalid_o(avalid_o), .addr_o(addr_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
    .ready_i(ready), .rdata_i(rdata), .rvalid_i(rvalid)
  );

  // Transaction-level model: who is locked, who owns a pending read, whose turn is next.
  int          m_lock, m_own, m_next, e_sel;
  bit          m_pend;
  logic        e_avalid;
  logic [1:0]  e_ready, e_rvalid;
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_wstrb;

  task automatic model_reset();
    m_lock = -1; m_own = 0; m_next = 0; m_pend = 0;
  endtask

  task automatic model_eval();
    int m;
    m = -1;
    e_avalid = 1'b0; e_ready = '0; e_rvalid = '0;
    e_addr = '0; e_wdata = '0; e_wstrb = '0;
    if (rst_n) begin
      if (m_pend) begin
        if (rvalid) e_rvalid = 2'(1 << m_own);
      end else if (m_lock >= 0) begin
        if (((avalid >> m_lock) & 2'b01) != 0) m = m_lock;
      end else begin
        for (int i = 0; i < N; i++)
          if (m < 0 && ((avalid >> ((m_next + i) % N)) & 2'b01) != 0) m = (m_next + i) % N;
      end
    end
    e_sel = m;
    if (m >= 0) begin
      e_avalid = 1'b1;
      e_addr   = addr[m*32 +: 32];
      e_wdata  = wdata[m*32 +: 32];
      e_wstrb  = wstrb[m*4 +: 4];
      e_ready  = ready ? 2'(1 << m) : 2'b00;
    end
  endtask

  task automatic model_update();
    if (!rst_n) model_reset();
    else if (cke) begin
      if (m_pend) begin
        if (rvalid) m_pend = 0;
      end else if (e_sel >= 0) begin
        if (ready) begin
          m_lock = -1;
          if (!FIXED) m_next = (e_sel + 1) % N;
          if (e_wstrb == 4'h0) begin m_pend = 1; m_own = e_sel; end
        end else m_lock = e_sel;
      end else m_lock = -1;
    end
  endtask

  task automatic idle_inputs();
    cke = 1'b1; avalid = '0; wstrb = '0; ready = 1'b0; rvalid = 1'b0; rdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; avalid = 2'b11; wstrb = 8'hFF; ready = 1'b1; rvalid = 1'b1;
    addr = {32'h200, 32'h100}; wdata = {32'hBBBB_0001, 32'hAAAA_0001};
    for (int c = 0; c < 2; c++) begin
      #1;
      total++; if (avalid_o !== 1'b0) begin bad++; $display("FAIL reset_avalid got=%b want=0", avalid_o); end
      total++; if (ready_o !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b want=00", ready_o); end
      total++; if (rvalid_o !== 2'b00) begin bad++; $display("FAIL reset_rvalid got=%b want=00", rvalid_o); end
      @(negedge clk);
    end
    rst_n = 1'b1; idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [31:0] want_a;
    addr = {32'h200, 32'h100}; wdata = {32'hBBBB_0002, 32'hAAAA_0002};
    wstrb = 8'hFF; ready = 1'b1; avalid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      int g;
      g = FIXED ? 0 : i % 2;
      want_a = (g == 1) ? 32'h200 : 32'h100;
      #1;
      total++; if (addr_o !== want_a) begin bad++; $display("FAIL rr_addr cyc=%0d got=%h want=%h", i, addr_o, want_a); end
      total++; if (ready_o !== 2'(1 << g)) begin bad++; $display("FAIL rr_ready cyc=%0d got=%b want=%b", i, ready_o, 2'(1 << g)); end
      total++; if (wdata_o !== wdata[g*32 +: 32]) begin bad++; $display("FAIL rr_wdata cyc=%0d got=%h want=%h", i, wdata_o, wdata[g*32 +: 32]); end
      @(negedge clk);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_read();
    addr = {32'h40, 32'h0}; wstrb = 8'h00; avalid = 2'b10; ready = 1'b1;
    #1;
    total++; if (avalid_o !== 1'b1 || addr_o !== 32'h40 || ready_o !== 2'b10) begin
      bad++; $display("FAIL read_req got=%b/%h/%b want=1/00000040/10", avalid_o, addr_o, ready_o); end
    @(negedge clk);
    avalid = 2'b00;
    #1;
    total++; if (avalid_o !== 1'b0 || rvalid_o !== 2'b00) begin
      bad++; $display("FAIL read_wait got=%b/%b want=0/00", avalid_o, rvalid_o); end
    @(negedge clk);
    avalid = 2'b01; rvalid = 1'b1; rdata = 32'hCAFEF00D;
    #1;
    total++; if (rvalid_o !== 2'b10) begin bad++; $display("FAIL read_rvalid got=%b want=10", rvalid_o); end
    total++; if (rdata_o[63:32] !== 32'hCAFEF00D) begin bad++; $display("FAIL read_rdata got=%h want=cafef00d", rdata_o[63:32]); end
    total++; if (avalid_o !== 1'b0) begin bad++; $display("FAIL read_bubble got=%b want=0", avalid_o); end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_grant_lock();
    logic [31:0] want_a;
    addr = {32'h400, 32'h300}; wstrb = 8'hFF; avalid = 2'b01; ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) avalid = 2'b11;
      #1;
      total++; if (addr_o !== 32'h300 || ready_o !== 2'b00) begin
        bad++; $display("FAIL lock_hold cyc=%0d got=%h/%b want=00000300/00", c, addr_o, ready_o); end
      @(negedge clk);
    end
    ready = 1'b1;
    #1;
    total++; if (addr_o !== 32'h300 || ready_o !== 2'b01) begin
      bad++; $display("FAIL lock_accept got=%h/%b want=00000300/01", addr_o, ready_o); end
    @(negedge clk);
    want_a = FIXED ? 32'h300 : 32'h400;
    #1;
    total++; if (addr_o !== want_a) begin bad++; $display("FAIL lock_next got=%h want=%h", addr_o, want_a); end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    addr = {32'h500, 32'h80}; wstrb = 8'h00; avalid = 2'b01; ready = 1'b1;
    @(negedge clk);
    avalid = 2'b00; rst_n = 1'b0; rvalid = 1'b1;
    #1;
    total++; if (rvalid_o !== 2'b00) begin bad++; $display("FAIL rstrd_in_reset got=%b want=00", rvalid_o); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      total++; if (rvalid_o !== 2'b00 || avalid_o !== 1'b0) begin
        bad++; $display("FAIL rstrd_late cyc=%0d got=%b/%b want=00/0", c, rvalid_o, avalid_o); end
      @(negedge clk);
    end
    rvalid = 1'b0; avalid = 2'b10; wstrb = 8'hF0;
    #1;
    total++; if (addr_o !== 32'h500 || ready_o !== 2'b10) begin
      bad++; $display("FAIL rstrd_regrant got=%h/%b want=00000500/10", addr_o, ready_o); end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_cke();
    addr = {32'h700, 32'h600}; wstrb = 8'hFF; avalid = 2'b01; ready = 1'b0; cke = 1'b0;
    #1;
    total++; if (avalid_o !== 1'b1 || addr_o !== 32'h600) begin
      bad++; $display("FAIL cke_fwd got=%b/%h want=1/00000600", avalid_o, addr_o); end
    @(negedge clk);
    avalid = 2'b10;
    #1;
    total++; if (avalid_o !== 1'b1 || addr_o !== 32'h700) begin
      bad++; $display("FAIL cke_nolock got=%b/%h want=1/00000700", avalid_o, addr_o); end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_random();
    rst_n = 1'b0; idle_inputs(); model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      avalid = 2'($urandom);
      addr   = {$urandom, $urandom};
      wdata  = {$urandom, $urandom};
      wstrb  = {($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom),
                ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom)};
      ready  = ($urandom_range(0, 3) != 0);
      rvalid = ($urandom_range(0, 2) == 0);
      rdata  = $urandom;
      cke    = ($urandom_range(0, 7) != 0);
      rst_n  = ($urandom_range(0, 63) != 0);
      #1;
      model_eval();
      total++; if (avalid_o !== e_avalid) begin bad++; $display("FAIL rnd_avalid cyc=%0d got=%b want=%b", c, avalid_o, e_avalid); end
      total++; if (ready_o !== e_ready) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", c, ready_o, e_ready); end
      total++; if (rvalid_o !== e_rvalid) begin bad++; $display("FAIL rnd_rvalid cyc=%0d got=%b want=%b", c, rvalid_o, e_rvalid); end
      total++; if ({addr_o, wdata_o, wstrb_o} !== {e_addr, e_wdata, e_wstrb}) begin
        bad++; $display("FAIL rnd_payload cyc=%0d got=%h/%h/%h want=%h/%h/%h", c, addr_o, wdata_o, wstrb_o, e_addr, e_wdata, e_wstrb); end
      total++; if (rdata_o !== {rdata, rdata}) begin bad++; $display("FAIL rnd_rdata cyc=%0d got=%h want=%h", c, rdata_o, {rdata, rdata}); end
      model_update();
      @(negedge clk);
    end
    rst_n = 1'b1; idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0; addr = '0; wdata = '0;
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_read();
    test_grant_lock();
    test_reset_mid_read();
    test_cke();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
